// File: rtl/gfe_row_scale.sv
// gfe_row_scale: row normalisation after the GF(3) pivot inverter.
// Latches the pivot inverse, then scales one row of N GF(3) elements
// (codes 0/1/2) by it through a valid/ready stream. A zero or illegal
// pivot raises the sticky singular flag and no row is accepted.
// Optional build macro: GFE_ROW_SCALE_SKID_EN selects a 2-entry skid
// buffer output stage with a registered din_ready. Without it the output
// is a single register and din_ready depends combinationally on dout_ready.
module gfe_row_scale #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pivot_valid,
  input  logic [1:0] inv_in,
  input  logic       inv_en,
  input  logic [1:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       singular,
  output logic       busy
);

  localparam int DATA_W = 2;
  localparam int COEF_W = 2;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // GF(3) product; the unused code 2'b11 on either operand yields 0.
  function automatic logic [DATA_W-1:0] gf3_mul(input logic [DATA_W-1:0] a,
                                                input logic [COEF_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    if (a == 2'd0 || a == 2'd3 || b == 2'd0 || b == 2'd3) begin
      r = '0;
    end else if (a == 2'd1) begin
      r = b;
    end else if (b == 2'd1) begin
      r = a;
    end else begin
      r = 2'd1;
    end
    return r;
  endfunction

  // A pivot is usable only when the inverter flagged it and the code is legal.
  function automatic logic pivot_ok(input logic en, input logic [COEF_W-1:0] inv);
    return en && (inv != 2'b11);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SCALE = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [COEF_W-1:0]   scale, scale_nxt;
  logic                sing_r, sing_nxt;
  logic                accept;
  logic [DATA_W-1:0]   prod_p0;
  logic                last_p0;

  // ---- stage p0: input acceptance and multiply ----
  assign accept  = din_valid && din_ready;
  assign prod_p0 = gf3_mul(din, scale);
  assign last_p0 = (cnt == CNT_LAST);

  // Control state register: FSM, element counter, latched inverse, singular flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      scale  <= '0;
      sing_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      scale  <= scale_nxt;
      sing_r <= sing_nxt;
    end
  end

  // Next-state logic: pivots are only looked at in IDLE; a row ends on its Nth accept.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    scale_nxt = scale;
    sing_nxt  = sing_r;
    case (state)
      IDLE: begin
        if (pivot_valid) begin
          if (pivot_ok(inv_en, inv_in)) begin
            scale_nxt = inv_in;
            sing_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = SCALE;
          end else begin
            sing_nxt  = 1'b1;
          end
        end
      end
      SCALE: begin
        if (accept) begin
          if (last_p0) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign singular = sing_r;

`ifdef GFE_ROW_SCALE_SKID_EN

  logic [DATA_W-1:0] buf_d_p1 [2];
  logic              buf_l_p1 [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        occ, occ_nxt;
  logic              rdy_r;
  logic              vld_p1;
  logic              pop;

  // ---- stage p1: two-entry skid buffer ----
  assign vld_p1 = (occ != 2'd0);
  assign pop    = vld_p1 && dout_ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    occ_nxt = occ;
    if (accept && !pop) begin
      occ_nxt = occ + 2'd1;
    end else if (!accept && pop) begin
      occ_nxt = occ - 2'd1;
    end
  end

  // Buffer entries carry their last flag; ready is precomputed from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_d_p1[0] <= '0;
      buf_d_p1[1] <= '0;
      buf_l_p1[0] <= 1'b0;
      buf_l_p1[1] <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= 2'd0;
      rdy_r       <= 1'b0;
    end else begin
      if (accept) begin
        buf_d_p1[wr_ptr] <= prod_p0;
        buf_l_p1[wr_ptr] <= last_p0;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ   <= occ_nxt;
      rdy_r <= (state_nxt == SCALE) && (occ_nxt < 2'd2);
    end
  end

  assign din_ready  = rdy_r;
  assign dout       = buf_d_p1[rd_ptr];
  assign dout_valid = vld_p1;
  assign dout_last  = buf_l_p1[rd_ptr] && vld_p1;
  assign busy       = (state != IDLE) || vld_p1;

`else

  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              last_p1;

  // ---- stage p1: single output register ----
  // Load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (accept) begin
      dout_p1 <= prod_p0;
      vld_p1  <= 1'b1;
      last_p1 <= last_p0;
    end else if (dout_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign din_ready  = (state == SCALE) && (!vld_p1 || dout_ready);
  assign dout       = dout_p1;
  assign dout_valid = vld_p1;
  assign dout_last  = last_p1;
  assign busy       = (state != IDLE) || vld_p1;

`endif

endmodule

// File: tb/tb_gfe_row_scale.sv
// Testbench for gfe_row_scale: table-driven rows, hand-written corner
// sequences and randomized rows against a GF(3) scoreboard.
module tb_gfe_row_scale;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pivot_valid = 1'b0;
  logic [1:0] inv_in = 2'd0;
  logic       inv_en = 1'b0;
  logic [1:0] din = 2'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [1:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_last;
  logic       singular;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  int beats = 0;
  int lasts = 0;
  logic [2:0] q[$];

  gfe_row_scale #(.N(N)) dut (
    .clk(clk), .rst(rst), .pivot_valid(pivot_valid), .inv_in(inv_in),
    .inv_en(inv_en), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .singular(singular), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     inv;
    logic [2*N-1:0] row;
    logic [2*N-1:0] exp;
    int             bp;
    int             mid;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {2'(a7), 2'(a6), 2'(a5), 2'(a4), 2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  // GF(3) reference: plain modular arithmetic, illegal code maps to 0.
  function automatic logic [1:0] gf3_ref(input int a, input int s);
    if (a > 2 || s > 2) return 2'd0;
    return 2'((a * s) % 3);
  endfunction

  // Output monitor: scoreboard pop on each transfer, hold check while stalled.
  initial begin
    logic       stall;
    logic [1:0] hd;
    logic       hl;
    logic [2:0] e;
    stall = 1'b0;
    hd = 2'd0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", dout_valid, 1);
          chk("hold_data", dout, hd);
          chk("hold_last", dout_last, hl);
        end
        if (dout_valid && dout_ready) begin
          if (q.size() == 0) begin
            chk("spurious_beat", dout_valid, 0);
          end else begin
            e = q.pop_front();
            chk("beat_data", dout, e[1:0]);
            chk("beat_last", dout_last, e[2]);
            beats++;
            if (dout_last) lasts++;
          end
        end
        stall = dout_valid && !dout_ready;
        hd = dout;
        hl = dout_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic do_pivot(input logic [1:0] inv, input logic en);
    pivot_valid = 1'b1;
    inv_in = inv;
    inv_en = en;
    @(posedge clk); #1;
    pivot_valid = 1'b0;
    inv_en = 1'b0;
  endtask

  // Present nsend elements of a row; bp: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic send_row(input logic [2*N-1:0] row, input logic [2*N-1:0] exp,
                          input int bp, input int mid, input int nsend);
    int   i;
    int   cyc;
    logic pulsed;
    logic acc;
    for (int k = 0; k < N; k++) q.push_back({(k == N - 1), exp[2*k +: 2]});
    i = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (i < nsend && cyc < 200) begin
      din_valid = 1'b1;
      din = row[2*i +: 2];
      case (bp)
        0: dout_ready = 1'b1;
        1: dout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (mid >= 0 && i == mid && !pulsed) begin
        pivot_valid = 1'b1;
        inv_in = 2'd1;
        inv_en = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      acc = din_ready;
      @(posedge clk); #1;
      pivot_valid = 1'b0;
      inv_en = 1'b0;
      if (acc) begin
        if (bp == 0) begin
          chk("latency_valid", dout_valid, 1);
          chk("latency_data", dout, exp[2*i +: 2]);
        end
        i++;
      end
      cyc++;
    end
    din_valid = 1'b0;
    chk("row_accepts", i, nsend);
  endtask

  task automatic drain(input int b0, input int l0, input int eb, input int el);
    int k;
    dout_ready = 1'b1;
    k = 0;
    while ((q.size() != 0 || dout_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
    chk("beat_count", beats - b0, eb);
    chk("last_count", lasts - l0, el);
    chk("idle_ready", din_ready, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int b0;
    int l0;
    logic [2*N-1:0] r;
    logic [2*N-1:0] x;
    logic [1:0] s;

    tbl[0] = '{inv: 2'd2, row: pk(0,1,2,1,2,0,1,2), exp: pk(0,2,1,2,1,0,2,1), bp: 0, mid: -1};
    tbl[1] = '{inv: 2'd1, row: pk(2,0,1,1,2,2,0,1), exp: pk(2,0,1,1,2,2,0,1), bp: 1, mid: -1};
    tbl[2] = '{inv: 2'd2, row: pk(1,3,2,3,1,2,0,2), exp: pk(2,0,1,0,2,1,0,1), bp: 0, mid: 3};
    tbl[3] = '{inv: 2'd1, row: pk(3,3,1,2,0,3,2,1), exp: pk(0,0,1,2,0,0,2,1), bp: 1, mid: -1};

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_last", dout_last, 0);
    chk("rst_singular", singular, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven rows
    for (int t = 0; t < 4; t++) begin
      do_pivot(tbl[t].inv, 1'b1);
      chk("pivot_singular_clear", singular, 0);
      b0 = beats;
      l0 = lasts;
      send_row(tbl[t].row, tbl[t].exp, tbl[t].bp, tbl[t].mid, N);
      drain(b0, l0, N, 1);
    end

    // Singular pivot blocks rows
    do_pivot(2'd1, 1'b0);
    chk("singular_set", singular, 1);
    chk("singular_busy", busy, 0);
    din_valid = 1'b1;
    din = 2'd1;
    dout_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("singular_no_ready", din_ready, 0);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    chk("singular_sticky", singular, 1);
    do_pivot(2'd1, 1'b1);
    chk("singular_cleared", singular, 0);
    r = pk(2,1,0,2,2,1,0,1);
    b0 = beats;
    l0 = lasts;
    send_row(r, r, 0, -1, N);
    drain(b0, l0, N, 1);
    // Illegal inverse code counts as singular
    do_pivot(2'd3, 1'b1);
    chk("illegal_inv_singular", singular, 1);
    @(negedge clk);
    chk("illegal_inv_no_ready", din_ready, 0);
    @(posedge clk); #1;

    // Back-to-back rows with the last beat held
    b0 = beats;
    l0 = lasts;
    do_pivot(2'd1, 1'b1);
    r = pk(1,2,2,0,1,1,2,0);
    send_row(r, r, 0, -1, N);
    dout_ready = 1'b0;
    chk("b2b_last_out", dout_last, 1);
    chk("b2b_valid_out", dout_valid, 1);
    do_pivot(2'd2, 1'b1);
    chk("b2b_busy", busy, 1);
    chk("b2b_last_still", dout_last, 1);
    @(posedge clk); #1;
    r = pk(1,1,2,0,2,1,0,2);
    send_row(r, pk(2,2,1,0,1,2,0,1), 0, -1, N);
    drain(b0, l0, 2 * N, 2);

    // Reset mid-row after 3 accepts
    do_pivot(2'd2, 1'b1);
    l0 = lasts;
    send_row(pk(1,2,1,2,1,2,1,2), pk(2,1,2,1,2,1,2,1), 0, -1, 3);
    rst = 1'b1;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    q.delete();
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_last", dout_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", din_ready, 0);
    chk("mid_rst_singular", singular, 0);
    rst = 1'b0;
    din_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", din_ready, 0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    chk("mid_rst_no_last", lasts - l0, 0);
    do_pivot(2'd1, 1'b1);
    b0 = beats;
    l0 = lasts;
    r = pk(0,1,2,2,1,0,1,2);
    send_row(r, r, 1, -1, N);
    drain(b0, l0, N, 1);

    // Randomized rows under random backpressure
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) do_pivot(2'($urandom_range(0, 3)), 1'b0);
        else do_pivot(2'd3, 1'b1);
        chk("rand_singular", singular, 1);
      end
      s = 2'($urandom_range(1, 2));
      do_pivot(s, 1'b1);
      chk("rand_singular_clear", singular, 0);
      for (int k = 0; k < N; k++) begin
        r[2*k +: 2] = 2'($urandom_range(0, 3));
        x[2*k +: 2] = gf3_ref(int'(r[2*k +: 2]), int'(s));
      end
      b0 = beats;
      l0 = lasts;
      send_row(r, x, 2, -1, N);
      drain(b0, l0, N, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
